mole_round_engine: RTL and testbench
====================================

Name: mole_round_engine

Overview:
- Parametrised successor to the single-channel game datapath for the whack-a-mole game.
- Runs a complete game of N_ROUNDS rounds. Each round lights one of N_MOLES moles, detects hits and misses from one-hot player buttons, and keeps a saturating score.
- At game end, writes the final score to the score RAM (wren/address/data_out) and raises game_over for the screen controller.
- Sits between the button synchroniser and the VGA/score-RAM blocks.

Parameters:
- N_MOLES, 4, number of mole channels; width of hit_btn and mole_onehot; 2..8.
- SCORE_W, 8, score and data_out width.
- ADDR_W, 5, score RAM address width.
- N_ROUNDS, 16, mole appearances per game; must be >= 1.
- TICK_DIV, 50000000, clk cycles per game tick; must be >= 2.
- SHOW_TICKS, 3, ticks a mole stays up.
- GAP_TICKS, 1, ticks with all moles down between rounds.
- MISS_PENALTY, 1, 1 = wrong-button press decrements score; 0 = ignored.

Ports:
- clk, input, 1, system clock.
- Reset, input, 1, synchronous active-high reset.
- start, input, 1, level or pulse; sampled only in IDLE and DONE.
- hit_btn, input, N_MOLES, synchronised player buttons, one bit per mole.
- mole_onehot, output, N_MOLES, currently raised mole; zero when none.
- score, output, SCORE_W, running score.
- round, output, 8, index of the current round, 0-based.
- busy, output, 1, high in LOAD/SHOW/GAP/SAVE.
- game_over, output, 1, high in DONE.
- wren, output, 1, score RAM write strobe, one cycle.
- address, output, ADDR_W, score RAM write address (slot pointer).
- data_out, output, SCORE_W, score RAM write data.

Behaviour:
- Reset (synchronous, clk edge with Reset=1): state=IDLE; all outputs 0; slot pointer 0; tick counter 0; LFSR=8'h5A. Reset mid-game aborts with no RAM write.
- Tick generator: counter 0..TICK_DIV-1, cleared on every state entry. Runs only in SHOW and GAP. Tick pulses one cycle when the counter equals TICK_DIV-1.
- LFSR: 8-bit, taps 8,6,5,4, steps every cycle in all states except reset.
- Mole select at SHOW entry: cand = lfsr mod N_MOLES. If cand equals the previous mole, use (cand+1) mod N_MOLES.
- Button edges: hit_btn is registered; rise = hit_btn & ~hit_btn_q.
- States:
  - IDLE: start=1 -> LOAD.
  - LOAD: one cycle; score=0, round=0 -> SHOW.
  - SHOW:
    - mole_onehot = 1 << sel.
    - rise on the sel bit -> hit: score+1, saturating at 2^SCORE_W-1; next cycle -> GAP with mole_onehot=0.
    - rise on any other bit with no hit that cycle and MISS_PENALTY=1 -> score-1, saturating at 0; stay in SHOW.
    - Simultaneous hit and wrong press in one cycle: hit counts, no penalty.
    - At most one hit per round.
    - Timeout after SHOW_TICKS ticks -> GAP, no score change.
  - GAP: mole_onehot=0; button rises ignored. After GAP_TICKS ticks: if round==N_ROUNDS-1 -> SAVE, else round+1 -> SHOW.
  - SAVE: one cycle; wren=1, address=slot, data_out=score. Slot increments on exit, wrapping from 2^ADDR_W-1 to 0. -> DONE.
  - DONE: game_over=1; score and round held. start=1 -> LOAD (new game; slot pointer kept).
- start outside IDLE/DONE is ignored.
- Latency: start sampled -> first mole visible 2 cycles later (LOAD, then SHOW registered).
- Outputs are registered; wren is 0 in every state except SAVE.

Optional Feature:
- Macro: MOLE_SPEEDUP_EN.
- Defined: show length for round r = max(SHOW_TICKS - r, 1) ticks; game gets faster each round.
- Undefined: every round lasts SHOW_TICKS ticks; no subtractor is synthesised.

Test Plan:
- Bench parameters: N_MOLES=4, TICK_DIV=4, SHOW_TICKS=3, GAP_TICKS=1, N_ROUNDS=3, SCORE_W=8, ADDR_W=5.
- Idle game: pulse start, never press -> each SHOW lasts 12 cycles and each GAP 4. After round 2, wren=1 for one cycle with address=0, data_out=0; then game_over=1, score=0.
- Perfect game: press the lit mole bit 2 cycles into each SHOW -> score 1,2,3. SAVE writes data_out=3 at address 0. A second game writes at address 1.
- Wrong press with MISS_PENALTY=1: score=2 then one wrong-bit rise -> score=1. Wrong press at score=0 -> stays 0. Hit and wrong bit in the same cycle -> +1 only.
- Held button: keep the lit bit high across a whole SHOW -> exactly one +1. A bit already high entering SHOW is not a hit.
- Saturation and wrap: SCORE_W=2, N_ROUNDS=5, hit every round -> score stops at 3. ADDR_W=1, three games -> addresses 0,1,0.
- Reset mid-SHOW with score=2: all outputs 0 next cycle, wren never asserted, address 0. Under MOLE_SPEEDUP_EN, round 2 SHOW lasts 1 tick (4 cycles).

Source files
------------

// File: rtl/mole_round_engine.sv
// rtl/mole_round_engine.sv - whack-a-mole round engine: N_ROUNDS rounds, hit/miss scoring, score RAM save; optional MOLE_SPEEDUP_EN shortens SHOW each round
module mole_round_engine #(
  parameter int N_MOLES      = 4,
  parameter int SCORE_W      = 8,
  parameter int ADDR_W       = 5,
  parameter int N_ROUNDS     = 16,
  parameter int TICK_DIV     = 50000000,
  parameter int SHOW_TICKS   = 3,
  parameter int GAP_TICKS    = 1,
  parameter int MISS_PENALTY = 1
) (
  input  logic               clk,
  input  logic               Reset,
  input  logic               start,
  input  logic [N_MOLES-1:0] hit_btn,
  output logic [N_MOLES-1:0] mole_onehot,
  output logic [SCORE_W-1:0] score,
  output logic [7:0]         round,
  output logic               busy,
  output logic               game_over,
  output logic               wren,
  output logic [ADDR_W-1:0]  address,
  output logic [SCORE_W-1:0] data_out
);

  localparam int SEL_W = $clog2(N_MOLES);
  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [N_MOLES-1:0] ONE = N_MOLES'(1);
  localparam logic [15:0] GAP_LAST = 16'(GAP_TICKS - 1);

  typedef enum logic [2:0] {IDLE, LOAD, SHOW, GAP, SAVE, DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [15:0]        tk_q, tk_d;
  logic [7:0]         lfsr_q, lfsr_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [N_MOLES-1:0] btn_q, mole_q, mole_d;
  logic [SCORE_W-1:0] score_q, score_d, dout_q, dout_d;
  logic [7:0]         round_q, round_d;
  logic               busy_q, busy_d, over_q, over_d, wren_q, wren_d;
  logic [ADDR_W-1:0]  addr_q, addr_d, slot_q, slot_d;

  logic [N_MOLES-1:0] rise;
  logic               tick, wrong;
  logic [SEL_W-1:0]   cand, new_sel;
  logic [15:0]        show_last;

  assign rise  = hit_btn & ~btn_q;
  assign wrong = |(rise & ~mole_q);
  assign tick  = ((state_q == SHOW) || (state_q == GAP)) && (cnt_q == CNT_W'(TICK_DIV - 1));

`ifdef MOLE_SPEEDUP_EN
  assign show_last = (int'(round_q) >= SHOW_TICKS - 1) ? 16'd0 : 16'(SHOW_TICKS - 1 - int'(round_q));
`else
  assign show_last = 16'(SHOW_TICKS - 1);
`endif

  // Next mole: LFSR modulo N_MOLES, bumped by one if it would repeat the previous mole
  always_comb begin
    cand    = SEL_W'(lfsr_q % 8'(N_MOLES));
    new_sel = cand;
    if (cand == sel_q) begin
      new_sel = (cand == SEL_W'(N_MOLES - 1)) ? '0 : cand + SEL_W'(1);
    end
  end

  // Next-state and registered-output logic for the game sequencer
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tk_d    = tk_q;
    sel_d   = sel_q;
    score_d = score_q;
    round_d = round_q;
    slot_d  = slot_q;
    addr_d  = addr_q;
    dout_d  = dout_q;
    lfsr_d  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

    case (state_q)
      IDLE, DONE: if (start) state_d = LOAD;
      LOAD: begin
        score_d = '0;
        round_d = '0;
        state_d = SHOW;
      end
      SHOW: begin
        if (rise[sel_q]) begin
          // a hit wins over a simultaneous wrong press and over a timeout
          if (score_q != '1) score_d = score_q + SCORE_W'(1);
          state_d = GAP;
        end else begin
          if (wrong && (MISS_PENALTY == 1) && (score_q != '0)) score_d = score_q - SCORE_W'(1);
          if (tick && (tk_q == show_last)) state_d = GAP;
        end
      end
      GAP: begin
        if (tick && (tk_q == GAP_LAST)) begin
          if (round_q == 8'(N_ROUNDS - 1)) begin
            state_d = SAVE;
          end else begin
            round_d = round_q + 8'd1;
            state_d = SHOW;
          end
        end
      end
      SAVE: begin
        slot_d  = slot_q + ADDR_W'(1);
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase

    // tick divider restarts on every state entry and only runs while a mole cycle is in progress
    if (state_d != state_q) begin
      cnt_d = '0;
      tk_d  = '0;
    end else if ((state_q == SHOW) || (state_q == GAP)) begin
      if (tick) begin
        cnt_d = '0;
        tk_d  = tk_q + 16'd1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    if ((state_d == SHOW) && (state_q != SHOW)) sel_d = new_sel;
    mole_d = (state_d == SHOW) ? (ONE << sel_d) : '0;
    busy_d = (state_d == LOAD) || (state_d == SHOW) || (state_d == GAP) || (state_d == SAVE);
    over_d = (state_d == DONE);
    wren_d = (state_d == SAVE);
    if (state_d == SAVE) begin
      addr_d = slot_q;
      dout_d = score_q;
    end
  end

  // State and datapath registers; synchronous reset aborts any game in progress
  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tk_q    <= '0;
      lfsr_q  <= 8'h5A;
      sel_q   <= '0;
      btn_q   <= '0;
      mole_q  <= '0;
      score_q <= '0;
      round_q <= '0;
      busy_q  <= 1'b0;
      over_q  <= 1'b0;
      wren_q  <= 1'b0;
      addr_q  <= '0;
      dout_q  <= '0;
      slot_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tk_q    <= tk_d;
      lfsr_q  <= lfsr_d;
      sel_q   <= sel_d;
      btn_q   <= hit_btn;
      mole_q  <= mole_d;
      score_q <= score_d;
      round_q <= round_d;
      busy_q  <= busy_d;
      over_q  <= over_d;
      wren_q  <= wren_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
      slot_q  <= slot_d;
    end
  end

  assign mole_onehot = mole_q;
  assign score       = score_q;
  assign round       = round_q;
  assign busy        = busy_q;
  assign game_over   = over_q;
  assign wren        = wren_q;
  assign address     = addr_q;
  assign data_out    = dout_q;

endmodule

// File: tb/tb_mole_round_engine.sv
// tb/tb_mole_round_engine.sv - table-driven game scenarios with score-RAM write scoreboard for mole_round_engine
module tb_mole_round_engine;

  typedef struct {
    bit          dut;
    int          nr;
    logic [14:0] act;
    logic [39:0] sc;
    int          exp_addr;
    int          exp_data;
    int          rst_round;
  } game_t;

  typedef struct {
    int addr;
    int data;
  } sb_t;

`ifdef MOLE_SPEEDUP_EN
  localparam bit SPEEDUP = 1'b1;
`else
  localparam bit SPEEDUP = 1'b0;
`endif

  logic clk, rst, start, dsel;
  logic [3:0] btn;
  logic [3:0] btn_a, btn_b, mole_a, mole_b, v_mole;
  logic start_a, start_b;
  logic [7:0] score_a, round_a, round_b, dout_a, v_score, v_round;
  logic [1:0] score_b, dout_b;
  logic busy_a, busy_b, over_a, over_b, wren_a, wren_b, v_busy, v_over;
  logic [4:0] addr_a;
  logic [0:0] addr_b;
  logic wa_prev, wb_prev;

  int n_tests, n_fail;
  sb_t q_a[$], q_b[$];
  sb_t ea, eb;
  game_t games[10];

  assign btn_a   = dsel ? 4'h0 : btn;
  assign btn_b   = dsel ? btn : 4'h0;
  assign start_a = start & ~dsel;
  assign start_b = start & dsel;
  assign v_mole  = dsel ? mole_b : mole_a;
  assign v_score = dsel ? {6'd0, score_b} : score_a;
  assign v_round = dsel ? round_b : round_a;
  assign v_busy  = dsel ? busy_b : busy_a;
  assign v_over  = dsel ? over_b : over_a;

  mole_round_engine #(
    .N_MOLES(4), .SCORE_W(8), .ADDR_W(5), .N_ROUNDS(3),
    .TICK_DIV(4), .SHOW_TICKS(3), .GAP_TICKS(1), .MISS_PENALTY(1)
  ) u_a (
    .clk(clk), .Reset(rst), .start(start_a), .hit_btn(btn_a),
    .mole_onehot(mole_a), .score(score_a), .round(round_a), .busy(busy_a),
    .game_over(over_a), .wren(wren_a), .address(addr_a), .data_out(dout_a)
  );

  mole_round_engine #(
    .N_MOLES(4), .SCORE_W(2), .ADDR_W(1), .N_ROUNDS(5),
    .TICK_DIV(4), .SHOW_TICKS(3), .GAP_TICKS(1), .MISS_PENALTY(1)
  ) u_b (
    .clk(clk), .Reset(rst), .start(start_b), .hit_btn(btn_b),
    .mole_onehot(mole_b), .score(score_b), .round(round_b), .busy(busy_b),
    .game_over(over_b), .wren(wren_b), .address(addr_b), .data_out(dout_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int idle_len(input int r);
    int t;
    t = SPEEDUP ? (((3 - r) > 1) ? (3 - r) : 1) : 3;
    return t * 4;
  endfunction

  function automatic logic [3:0] rotl(input logic [3:0] v);
    return {v[2:0], v[3]};
  endfunction

  function automatic game_t mk(input bit d, input int nr, input logic [14:0] act,
                               input logic [39:0] sc, input int ad, input int da, input int rr);
    game_t g;
    g.dut = d; g.nr = nr; g.act = act; g.sc = sc;
    g.exp_addr = ad; g.exp_data = da; g.rst_round = rr;
    return g;
  endfunction

  // score RAM write monitors: single-cycle strobe, address/data against the expected queue
  always @(negedge clk) begin
    if (wren_a) begin
      chk("wren_a_single", wa_prev, 0);
      chk("sb_a_expected", q_a.size() != 0, 1);
      if (q_a.size() != 0) begin
        ea = q_a.pop_front();
        chk("ram_addr_a", addr_a, ea.addr);
        chk("ram_data_a", dout_a, ea.data);
      end
    end
    wa_prev = wren_a;
  end

  always @(negedge clk) begin
    if (wren_b) begin
      chk("wren_b_single", wb_prev, 0);
      chk("sb_b_expected", q_b.size() != 0, 1);
      if (q_b.size() != 0) begin
        eb = q_b.pop_front();
        chk("ram_addr_b", addr_b, eb.addr);
        chk("ram_data_b", dout_b, eb.data);
      end
    end
    wb_prev = wren_b;
  end

  // actions: 0 idle (stray start mid-SHOW), 1 hit, 2 wrong press, 3 hit+wrong, 4 hit and hold, 5 all held from GAP
  task automatic play(input game_t g);
    logic [3:0] lit, prev;
    int w, c, a;
    bit aborted;
    dsel = g.dut;
    prev = 4'h0;
    aborted = 1'b0;
    if (g.rst_round < 0) begin
      if (g.dut) q_b.push_back(sb_t'{g.exp_addr, g.exp_data});
      else       q_a.push_back(sb_t'{g.exp_addr, g.exp_data});
    end
    start = 1'b1;
    for (int r = 0; r < g.nr; r++) begin
      a = int'(g.act[3*r +: 3]);
      btn = (a == 5) ? 4'hF : 4'h0;
      w = 0;
      while (v_mole == 4'h0 && w < 50) begin
        @(negedge clk);
        w++;
        start = 1'b0;
      end
      chk("gap_len", w, (r == 0) ? 2 : 4);
      if (v_mole == 4'h0) begin
        aborted = 1'b1;
        break;
      end
      lit = v_mole;
      chk("mole_onehot", $onehot(lit), 1);
      if (r > 0) chk("mole_new", lit != prev, 1);
      chk("round_idx", v_round, r);
      prev = lit;
      c = 0;
      while (v_mole != 4'h0 && c < 100) begin
        if (r == g.rst_round && c == 1) begin
          rst = 1'b1;
          @(negedge clk);
          rst = 1'b0;
          chk("rst_mid_game", {mole_a, score_a, round_a, busy_a, over_a, wren_a, addr_a, dout_a}, 0);
          aborted = 1'b1;
          break;
        end
        if (c == 2 && (a == 1 || a == 4)) btn = lit;
        if (c == 2 && a == 2) btn = rotl(lit);
        if (c == 2 && a == 3) btn = lit | rotl(lit);
        if (c == 3 && a == 2) btn = 4'h0;
        if (c == 4 && a == 0) start = 1'b1;
        if (c == 5 && a == 0) start = 1'b0;
        @(negedge clk);
        c++;
      end
      start = 1'b0;
      if (aborted) break;
      chk("show_len", c, (a == 1 || a == 3 || a == 4) ? 3 : idle_len(r));
      chk("round_score", v_score, g.sc[8*r +: 8]);
    end
    btn = 4'h0;
    start = 1'b0;
    if (!aborted) begin
      w = 0;
      while (!v_over && w < 40) begin
        @(negedge clk);
        w++;
      end
      chk("game_over", v_over, 1);
      chk("final_score", v_score, g.exp_data);
      chk("final_round", v_round, g.nr - 1);
      chk("busy_done", v_busy, 0);
    end else begin
      repeat (10) @(negedge clk);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    wa_prev = 1'b0;
    wb_prev = 1'b0;
    rst = 1'b1;
    start = 1'b0;
    btn = 4'h0;
    dsel = 1'b0;

    games[0] = mk(0, 3, {3'd0, 3'd0, 3'd0, 3'd0, 3'd0}, {8'd0, 8'd0, 8'd0, 8'd0, 8'd0}, 0, 0, -1);
    games[1] = mk(0, 3, {3'd0, 3'd0, 3'd1, 3'd1, 3'd1}, {8'd0, 8'd0, 8'd3, 8'd2, 8'd1}, 1, 3, -1);
    games[2] = mk(0, 3, {3'd0, 3'd0, 3'd2, 3'd1, 3'd1}, {8'd0, 8'd0, 8'd1, 8'd2, 8'd1}, 2, 1, -1);
    games[3] = mk(0, 3, {3'd0, 3'd0, 3'd0, 3'd3, 3'd2}, {8'd0, 8'd0, 8'd1, 8'd1, 8'd0}, 3, 1, -1);
    games[4] = mk(0, 3, {3'd0, 3'd0, 3'd1, 3'd5, 3'd4}, {8'd0, 8'd0, 8'd2, 8'd1, 8'd1}, 4, 2, -1);
    games[5] = mk(0, 3, {3'd0, 3'd0, 3'd1, 3'd1, 3'd1}, {8'd0, 8'd0, 8'd0, 8'd2, 8'd1}, 0, 0, 2);
    games[6] = mk(0, 3, {3'd0, 3'd0, 3'd0, 3'd0, 3'd1}, {8'd0, 8'd0, 8'd1, 8'd1, 8'd1}, 0, 1, -1);
    games[7] = mk(1, 5, {3'd1, 3'd1, 3'd1, 3'd1, 3'd1}, {8'd3, 8'd3, 8'd3, 8'd2, 8'd1}, 0, 3, -1);
    games[8] = mk(1, 5, {3'd1, 3'd1, 3'd1, 3'd1, 3'd1}, {8'd3, 8'd3, 8'd3, 8'd2, 8'd1}, 1, 3, -1);
    games[9] = mk(1, 5, {3'd1, 3'd1, 3'd1, 3'd1, 3'd1}, {8'd3, 8'd3, 8'd3, 8'd2, 8'd1}, 0, 3, -1);

    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_outs_a", {mole_a, score_a, round_a, busy_a, over_a, wren_a, addr_a, dout_a}, 0);
    chk("reset_outs_b", {mole_b, score_b, round_b, busy_b, over_b, wren_b, addr_b, dout_b}, 0);
    repeat (2) @(negedge clk);
    chk("idle_hold_a", {mole_a, busy_a, over_a, wren_a}, 0);

    for (int i = 0; i < 10; i++) play(games[i]);

    repeat (5) @(negedge clk);
    chk("sb_a_drained", q_a.size(), 0);
    chk("sb_b_drained", q_b.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
